// File: rtl/spike_pkg.sv
// Shared definitions for the spike-processing stages: FSM state type,
// default widths and a saturating increment used wherever spikes are tallied.
package spike_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 8;

   // Width-agnostic: callers widen to 32 bits and truncate the result back.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] lim,
                                           input logic        inc);
      return (inc && (val < lim)) ? val + 32'd1 : val;
   endfunction

endpackage

// File: rtl/spike_rate_counter_window_timer.sv
// Window timer: latches the window length at start and flags the first and
// last cycles of each window. A length of 0 wraps to 2^WIN_W cycles.
module window_timer
   import spike_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             advance,
   input  logic [WIN_W-1:0] window_len,
   output logic             first,
   output logic             last
);

   logic [WIN_W-1:0] remain;
   logic             first_q;

   // Down-counter loaded with N-1; 0 - 1 wraps to all-ones, giving 2^WIN_W cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         remain  <= '0;
         first_q <= 1'b0;
      end else if (start) begin
         remain  <= window_len - WIN_W'(1);
         first_q <= 1'b1;
      end else if (advance) begin
         remain  <= remain - WIN_W'(1);
         first_q <= 1'b0;
      end
   end

   assign first = first_q;
   assign last  = (remain == '0);

endmodule

// File: rtl/spike_rate_counter.sv
// Per-neuron spike rate counter: tallies spikes over a programmable window and
// publishes each count through a valid/ready slot. SPIKE_RATE_ISI_EN adds isi_min.
//
// state | meaning
// IDLE  | no window running; waits for enable
// COUNT | window in progress; last cycle publishes and may restart
module spike_rate_counter
   import spike_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spike,
   input  logic             enable,
   input  logic [WIN_W-1:0] window_len,
   output logic [CNT_W-1:0] count,
   output logic             count_sat,
   output logic             count_valid,
   input  logic             count_ready,
   output logic             overrun,
   output logic             busy
`ifdef SPIKE_RATE_ISI_EN
   ,
   output logic [WIN_W-1:0] isi_min
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic             start, publish, drop, slot_free;
   logic             win_first, win_last;
   logic [CNT_W-1:0] acc, acc_base, acc_nxt;
   logic             sat, sat_base, sat_nxt;

   window_timer #(.WIN_W(WIN_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .advance    (state == COUNT),
      .window_len (window_len),
      .first      (win_first),
      .last       (win_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // The first window cycle counts from zero regardless of the stale accumulator.
   always_comb begin
      acc_base  = win_first ? '0 : acc;
      sat_base  = win_first ? 1'b0 : sat;
      acc_nxt   = CNT_W'(sat_inc(32'(acc_base), 32'(CNT_MAX), spike));
      sat_nxt   = sat_base | (spike && (acc_base == CNT_MAX));
      slot_free = !count_valid || count_ready;
      state_nxt = state;
      start     = 1'b0;
      publish   = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               start     = 1'b1;
               state_nxt = COUNT;
            end
         end
         COUNT: begin
            if (win_last) begin
               publish = slot_free;
               drop    = !slot_free;
               if (enable) start     = 1'b1;
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc         <= '0;
         sat         <= 1'b0;
         count       <= '0;
         count_sat   <= 1'b0;
         count_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (state == COUNT) begin
            acc <= acc_nxt;
            sat <= sat_nxt;
         end
         if (publish) begin
            count       <= acc_nxt;
            count_sat   <= sat_nxt;
            count_valid <= 1'b1;
         end else if (count_valid && count_ready) begin
            count_valid <= 1'b0;
         end
         if (drop) overrun <= 1'b1;
      end
   end

   assign busy = (state == COUNT);

`ifdef SPIKE_RATE_ISI_EN
   logic [WIN_W-1:0] gap, isi_acc, isi_base, isi_nxt;
   logic             seen, seen_base;

   // gap = cycles since the previous spike in this window; only valid once seen.
   always_comb begin
      seen_base = win_first ? 1'b0 : seen;
      isi_base  = win_first ? '1 : isi_acc;
      isi_nxt   = (spike && seen_base && (gap < isi_base)) ? gap : isi_base;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gap     <= '0;
         seen    <= 1'b0;
         isi_acc <= '1;
         isi_min <= '1;
      end else begin
         if (state == COUNT) begin
            isi_acc <= isi_nxt;
            if (spike) begin
               gap  <= WIN_W'(1);
               seen <= 1'b1;
            end else begin
               gap  <= gap + WIN_W'(1);
               seen <= seen_base;
            end
         end
         if (publish) isi_min <= isi_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_spike_rate_counter.sv
// Bench for spike_rate_counter: vector table, directed corner sequences and
// random traffic against a window-level reference model.
module tb_spike_rate_counter;

   localparam int CNT_W = 8;
   localparam int WIN_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             spike = 1'b0;
   logic             enable = 1'b0;
   logic [WIN_W-1:0] window_len = '0;
   logic             count_ready = 1'b0;
   logic [CNT_W-1:0] count;
   logic             count_sat, count_valid, overrun, busy;
`ifdef SPIKE_RATE_ISI_EN
   logic [WIN_W-1:0] isi_min;
`endif

   spike_rate_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .spike       (spike),
      .enable      (enable),
      .window_len  (window_len),
      .count       (count),
      .count_sat   (count_sat),
      .count_valid (count_valid),
      .count_ready (count_ready),
      .overrun     (overrun),
      .busy        (busy)
`ifdef SPIKE_RATE_ISI_EN
      ,
      .isi_min     (isi_min)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a window is a list of sampled spikes; its result is the
   // clipped sum and the smallest gap between consecutive spike positions.
   bit m_active = 0;
   int m_n, m_pos, m_sum, m_last, m_isi;
   int e_count = 0, e_sat = 0, e_valid = 0, e_ovr = 0, e_isi = 255;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic open_window(int wl);
      m_n    = (wl == 0) ? 256 : wl;
      m_pos  = 0;
      m_sum  = 0;
      m_last = -1;
      m_isi  = 255;
   endtask

   task automatic model_step(bit rst, bit en, bit sp, int wl, bit rdy);
      bit xfer, pub;
      if (rst) begin
         m_active = 0;
         e_count = 0; e_sat = 0; e_valid = 0; e_ovr = 0; e_isi = 255;
         return;
      end
      xfer = (e_valid != 0) && rdy;
      pub  = 0;
      if (!m_active) begin
         if (en) begin
            m_active = 1;
            open_window(wl);
         end
      end else begin
         if (sp) begin
            m_sum++;
            if (m_last >= 0 && (m_pos - m_last) < m_isi) m_isi = m_pos - m_last;
            m_last = m_pos;
         end
         m_pos++;
         if (m_pos == m_n) begin
            if (e_valid == 0 || rdy) begin
               pub     = 1;
               e_count = (m_sum > 255) ? 255 : m_sum;
               e_sat   = (m_sum > 255) ? 1 : 0;
               e_valid = 1;
               e_isi   = m_isi;
            end else begin
               e_ovr = 1;
            end
            if (en) open_window(wl);
            else    m_active = 0;
         end
      end
      if (!pub && xfer) e_valid = 0;
   endtask

   task automatic cyc(bit rst, bit en, bit sp, int wl, bit rdy);
      @(negedge clk);
      reset       = rst;
      enable      = en;
      spike       = sp;
      window_len  = WIN_W'(wl);
      count_ready = rdy;
      @(posedge clk);
      model_step(rst, en, sp, wl, rdy);
      #1;
      chk("model_count", 32'(count), 32'(e_count));
      chk("model_sat", 32'(count_sat), 32'(e_sat));
      chk("model_valid", 32'(count_valid), 32'(e_valid));
      chk("model_overrun", 32'(overrun), 32'(e_ovr));
      chk("model_busy", 32'(busy), 32'(m_active));
`ifdef SPIKE_RATE_ISI_EN
      chk("model_isi", 32'(isi_min), 32'(e_isi));
`endif
   endtask

   typedef struct {
      bit rst; bit en; bit sp; int wl; bit rdy;
      int e_cnt; bit e_sat; bit e_val; bit e_ovr; bit e_busy;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      bit r_rst, r_en, r_sp, r_rdy;
      int r_wl;

      // Window length 1: each cycle is a whole window, results back-to-back.
      tbl[0] = '{1, 0, 0, 1, 1,  0, 0, 0, 0, 0};
      tbl[1] = '{0, 1, 1, 1, 1,  0, 0, 0, 0, 1};
      tbl[2] = '{0, 1, 1, 1, 1,  1, 0, 1, 0, 1};
      tbl[3] = '{0, 1, 0, 1, 1,  0, 0, 1, 0, 1};
      tbl[4] = '{0, 1, 1, 1, 1,  1, 0, 1, 0, 1};
      tbl[5] = '{0, 0, 0, 1, 1,  0, 0, 1, 0, 0};
      tbl[6] = '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0};
      for (int i = 0; i < 7; i++) begin
         cyc(tbl[i].rst, tbl[i].en, tbl[i].sp, tbl[i].wl, tbl[i].rdy);
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_sat", i), 32'(count_sat), 32'(tbl[i].e_sat));
         chk($sformatf("tbl%0d_valid", i), 32'(count_valid), 32'(tbl[i].e_val));
         chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      end

      // Window of 10, spikes at offsets 2,5,9; result 11 cycles after start.
      cyc(1, 0, 0, 10, 1);
      cyc(0, 1, 1, 10, 1);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, (i == 2 || i == 5 || i == 9), 10, 1);
         if (i == 8) chk("w10_valid_early", 32'(count_valid), 32'd0);
      end
      chk("w10_count", 32'(count), 32'd3);
      chk("w10_valid", 32'(count_valid), 32'd1);
      chk("w10_sat", 32'(count_sat), 32'd0);
      cyc(0, 0, 0, 10, 1);
      chk("w10_valid_drop", 32'(count_valid), 32'd0);

      // window_len 0 = 256 cycles of spikes saturates an 8-bit count.
      cyc(1, 0, 0, 0, 1);
      cyc(0, 1, 1, 0, 1);
      for (int i = 0; i < 256; i++) cyc(0, 0, 1, 0, 1);
      chk("w256_count", 32'(count), 32'd255);
      chk("w256_sat", 32'(count_sat), 32'd1);
      chk("w256_valid", 32'(count_valid), 32'd1);

      // Stalled consumer: second window is dropped, third republishes.
      cyc(1, 0, 0, 4, 0);
      cyc(0, 1, 1, 4, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 4, 0);
      chk("stall_w1_count", 32'(count), 32'd4);
      chk("stall_w1_ovr", 32'(overrun), 32'd0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 4, 0);
      chk("stall_w2_ovr", 32'(overrun), 32'd1);
      chk("stall_w2_count", 32'(count), 32'd4);
      chk("stall_w2_valid", 32'(count_valid), 32'd1);
      cyc(0, 1, 1, 4, 1);
      chk("stall_xfer_valid", 32'(count_valid), 32'd0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 4, 0);
      chk("stall_w3_count", 32'(count), 32'd4);
      chk("stall_w3_valid", 32'(count_valid), 32'd1);

      // Reset mid-window after three spikes, then a clean window.
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 4, 0);
      cyc(1, 1, 1, 4, 0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(count_valid), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      cyc(0, 1, 0, 5, 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, (i == 1 || i == 3), 5, 1);
      chk("post_rst_count", 32'(count), 32'd2);
      chk("post_rst_ovr", 32'(overrun), 32'd0);

`ifdef SPIKE_RATE_ISI_EN
      cyc(1, 0, 0, 20, 1);
      cyc(0, 1, 0, 20, 1);
      for (int i = 0; i < 20; i++) cyc(0, 0, (i == 3 || i == 7 || i == 9 || i == 15), 20, 1);
      chk("isi_count", 32'(count), 32'd4);
      chk("isi_min", 32'(isi_min), 32'd2);
      cyc(0, 1, 0, 20, 1);
      for (int i = 0; i < 20; i++) cyc(0, 0, (i == 6), 20, 1);
      chk("isi_single_count", 32'(count), 32'd1);
      chk("isi_single", 32'(isi_min), 32'd255);
`endif

      // Random traffic against the model.
      cyc(1, 0, 0, 3, 1);
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 199) == 0);
         r_en  = ($urandom_range(0, 9) < 7);
         r_sp  = $urandom_range(0, 1) != 0;
         r_wl  = $urandom_range(0, 12);
         r_rdy = ($urandom_range(0, 3) != 0);
         cyc(r_rst, r_en, r_sp, r_wl, r_rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spike_rate_counter.md
Name: spike_rate_counter

Overview:
- Downstream consumer of a neuron's spike output.
- Counts spikes over a programmable window of clock cycles and presents each window's count to the readout or next layer through a valid/ready output register.
- Turns the 1-bit spike train into a rate-coded magnitude.
- One instance per neuron.

Parameters:
- CNT_W, 8, width of spike count and its saturation limit.
- WIN_W, 8, width of window_len; window lengths range 1..2^WIN_W cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- spike  input  1  spike from the neuron stage, sampled every cycle.
- enable  input  1  run request; level-sensitive.
- window_len  input  WIN_W  window length in cycles; 0 encodes 2^WIN_W. Sampled only at window start.
- count  output  CNT_W  spike count of the last completed window.
- count_sat  output  1  the published count saturated.
- count_valid  output  1  count/count_sat hold an unconsumed result.
- count_ready  input  1  consumer accepts; transfer happens when valid && ready.
- overrun  output  1  sticky: a window result was dropped because the output slot was full.
- busy  output  1  high while a window is in progress.

Behaviour:
- Reset (synchronous, active-high, highest priority, may occur mid-window): state=IDLE; count=0, count_sat=0, count_valid=0, overrun=0, busy=0; accumulator and window timer cleared. Any in-progress window is discarded.
- FSM has two states, IDLE and COUNT.
- IDLE to COUNT: when enable=1.
  - In that cycle, window_len is latched as N and acc is cleared.
  - spike in the IDLE cycle is not counted.
- COUNT:
  - Each cycle with spike=1 increments acc.
  - At the limit 2^CNT_W-1, acc holds and a sat flag is set.
  - The timer counts 0..N-1. busy=1.
- Last window cycle (timer==N-1):
  - The final value is acc plus the current spike, saturated.
  - Publish if the slot is free (count_valid==0, or count_valid && count_ready this cycle). The next cycle then shows count=final, count_sat=flag, count_valid=1.
  - Latency: the result is visible 1 cycle after the last sampled spike.
  - If the slot is not free, the result is dropped, count/count_sat are unchanged, and overrun is set; overrun clears only on reset.
- Back-to-back windows:
  - If enable=1 in the last cycle, window_len is re-latched, acc and timer are cleared, and the next cycle is the first cycle of the new window. There is no gap cycle.
  - Otherwise go to IDLE and busy=0.
- Deasserting enable mid-window does not abort; the window completes.
- Handshake:
  - count_valid stays high until valid && ready.
  - count and count_sat are stable while valid=1.
  - When a transfer and a publish happen in the same cycle, the new result replaces the old one and valid stays 1.
  - count_ready while valid=0 is ignored.
- N=1: every cycle is both first and last; each window's result equals spike (0/1).
- Window changes: a window_len change mid-window has no effect until the next window start.

Optional Feature:
- Macro: SPIKE_RATE_ISI_EN.
- With the macro defined:
  - Adds output isi_min (WIN_W bits): the minimum inter-spike interval in cycles within the window. It is published and held with count under the same handshake.
  - isi_min reads all-ones if fewer than 2 spikes occurred.
  - Intervals do not span window boundaries.
  - Reset value is all-ones.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package spike_pkg holds:
  - the state enum (IDLE, COUNT);
  - default CNT_W/WIN_W constants;
  - a saturating-increment function reused by other spike stages.
- Natural sub-module: window_timer. It holds N, counts cycles, and flags the first and last window cycles, including the N=1 and N=0 (meaning 2^WIN_W) cases.

Test Plan:
- reset, enable=1, window_len=10, spike high on cycles 2,5,9 of the window, count_ready=1 -> count=3, count_valid=1 for one cycle, exactly 11 cycles after the IDLE-to-COUNT cycle; count_sat=0.
- window_len=0 (256 cycles), spike held 1, CNT_W=8 -> count=255, count_sat=1.
- enable held 1, window_len=4, count_ready=0, spike=1 constantly -> first result count=4 is valid and held; the second window's result is dropped, overrun=1, count stays 4. Raising ready then gives a transfer, and the third window's result publishes count=4.
- window_len=1, spike pattern 1,0,1 with ready=1 -> counts 1,0,1 on consecutive cycles, no gap cycles.
- Assert reset mid-window after 3 spikes -> all outputs 0 next cycle. A subsequent window counts from 0 with no carryover; overrun is cleared.
- SPIKE_RATE_ISI_EN defined, window_len=20, spikes on cycles 3,7,9,15 -> count=4, isi_min=2. A window with a single spike gives isi_min=all-ones.
